noc_out_ctrl: RTL and testbench

- Per-output-port control stage directly downstream of the fixed-priority switch arbiter in the router.
- Consumes the arbiter's one-hot grant and locks the output to the granted input port for the whole wormhole packet (head to tail).
- Muxes that port's flits onto the output link and manages credit-based flow control toward the downstream router.
- Exports busy/lock status so the request logic can mask new requests while a packet is in flight.

---
 rtl/noc_out_ctrl.sv | 169 ++++++++++++++++
 tb/tb_noc_out_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_out_ctrl.sv
// Per-output-port control stage: locks the output to one granted input for a
// whole wormhole packet, registers the forwarded flit and tracks downstream credits.
module noc_out_ctrl #(
  parameter int PORTS   = 5,
  parameter int DATA_W  = 32,
  parameter int CREDITS = 4,
  parameter int CNT_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst_,
  input  logic [PORTS-1:0]          grt,
  input  logic [PORTS*DATA_W-1:0]   idata,
  input  logic [PORTS*2-1:0]        itype,
  input  logic [PORTS-1:0]          ivalid,
  output logic [PORTS-1:0]          iack,
  output logic [DATA_W-1:0]         odata,
  output logic [1:0]                otype,
  output logic                      ovalid,
  input  logic                      credit_in,
  output logic [CNT_W-1:0]          credit_cnt,
  output logic                      busy,
  output logic [PORTS-1:0]          lock_sel,
  output logic                      err
);

  localparam logic [1:0] FLIT_HEAD_TAIL = 2'b00;
  localparam logic [1:0] FLIT_HEAD      = 2'b01;
  localparam logic [1:0] FLIT_BODY      = 2'b10;
  localparam logic [1:0] FLIT_TAIL      = 2'b11;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state_q, state_d;
  logic [PORTS-1:0]  lock_sel_q, lock_sel_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic [1:0]        otype_q, otype_d;
  logic              ovalid_q, ovalid_d;
  logic [CNT_W-1:0]  credit_cnt_q, credit_cnt_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] data_arr [PORTS];
  logic [1:0]        type_arr [PORTS];

  generate
    for (genvar gi = 0; gi < PORTS; gi++) begin : g_split
      assign data_arr[gi] = idata[gi*DATA_W +: DATA_W];
      assign type_arr[gi] = itype[gi*2 +: 2];
    end
  endgenerate

  logic [PORTS-1:0]  grt_low;
  logic [PORTS-1:0]  sel_oh;
  logic [DATA_W-1:0] sel_data;
  logic [1:0]        sel_type;
  logic              sel_valid;
  logic              head_like;
  logic              has_credit;
  logic              credit_full;
  logic              accept;
  logic              overflow;

  // Isolating the lowest set bit resolves a multi-hot grant to the lowest index.
  assign grt_low = grt & (~grt + PORTS'(1));
  assign sel_oh  = (state_q == ACTIVE) ? lock_sel_q : grt_low;

  always_comb begin
    sel_data  = '0;
    sel_type  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (sel_oh[i]) begin
        sel_data  = sel_data | data_arr[i];
        sel_type  = sel_type | type_arr[i];
        sel_valid = sel_valid | ivalid[i];
      end
    end
  end

  assign head_like   = (sel_type == FLIT_HEAD_TAIL) || (sel_type == FLIT_HEAD);
  assign has_credit  = (credit_cnt_q != '0);
  assign credit_full = (credit_cnt_q == CNT_W'(CREDITS));
  // A locked port forwards every flit type; an idle port only starts on a head.
  assign accept      = sel_valid && has_credit && ((state_q == ACTIVE) || head_like);
  assign overflow    = credit_in && !accept && credit_full;
  assign iack        = accept ? sel_oh : '0;

  always_comb begin
    state_d      = state_q;
    lock_sel_d   = lock_sel_q;
    odata_d      = odata_q;
    otype_d      = otype_q;
    ovalid_d     = accept;
    credit_cnt_d = credit_cnt_q;
    err_d        = err_q;

    if (accept) begin
      odata_d = sel_data;
      otype_d = sel_type;
    end

    unique case ({accept, credit_in})
      2'b10:   credit_cnt_d = credit_cnt_q - CNT_W'(1);
      2'b01:   credit_cnt_d = credit_full ? credit_cnt_q : credit_cnt_q + CNT_W'(1);
      default: credit_cnt_d = credit_cnt_q;
    endcase

    if (overflow) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (sel_valid && !head_like) begin
          err_d = 1'b1;
        end
        if (accept && sel_type == FLIT_HEAD) begin
          state_d    = ACTIVE;
          lock_sel_d = sel_oh;
        end
      end
      ACTIVE: begin
        if (accept && head_like) begin
          err_d = 1'b1;
        end
        if (accept && sel_type == FLIT_TAIL) begin
          state_d    = IDLE;
          lock_sel_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        lock_sel_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q      <= IDLE;
      lock_sel_q   <= '0;
      odata_q      <= '0;
      otype_q      <= FLIT_HEAD_TAIL;
      ovalid_q     <= 1'b0;
      credit_cnt_q <= CNT_W'(CREDITS);
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_sel_q   <= lock_sel_d;
      odata_q      <= odata_d;
      otype_q      <= otype_d;
      ovalid_q     <= ovalid_d;
      credit_cnt_q <= credit_cnt_d;
      err_q        <= err_d;
    end
  end

  assign odata      = odata_q;
  assign otype      = otype_q;
  assign ovalid     = ovalid_q;
  assign credit_cnt = credit_cnt_q;
  assign busy       = (state_q == ACTIVE);
  assign lock_sel   = lock_sel_q;
  assign err        = err_q;

  // Flit type encodings kept for readability of the case decodes above.
  logic unused_enc;
  assign unused_enc = ^{FLIT_BODY};

endmodule

// File: tb/tb_noc_out_ctrl.sv
// Bench for noc_out_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic checked against a packet-level reference model.
module tb_noc_out_ctrl;
  localparam int PORTS   = 5;
  localparam int DATA_W  = 32;
  localparam int CREDITS = 4;
  localparam int CNT_W   = 3;

  localparam logic [1:0] HT = 2'b00;
  localparam logic [1:0] HD = 2'b01;
  localparam logic [1:0] BD = 2'b10;
  localparam logic [1:0] TL = 2'b11;

  logic                    clk = 1'b0;
  logic                    rst_;
  logic [PORTS-1:0]        grt;
  logic [PORTS*DATA_W-1:0] idata;
  logic [PORTS*2-1:0]      itype;
  logic [PORTS-1:0]        ivalid;
  logic [PORTS-1:0]        iack;
  logic [DATA_W-1:0]       odata;
  logic [1:0]              otype;
  logic                    ovalid;
  logic                    credit_in;
  logic [CNT_W-1:0]        credit_cnt;
  logic                    busy;
  logic [PORTS-1:0]        lock_sel;
  logic                    err;

  always #5 clk = ~clk;

  noc_out_ctrl #(.PORTS(PORTS), .DATA_W(DATA_W), .CREDITS(CREDITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_(rst_), .grt(grt), .idata(idata), .itype(itype), .ivalid(ivalid),
    .iack(iack), .odata(odata), .otype(otype), .ovalid(ovalid), .credit_in(credit_in),
    .credit_cnt(credit_cnt), .busy(busy), .lock_sel(lock_sel), .err(err)
  );

  typedef struct {
    logic       rst_;
    logic [4:0] grt;
    logic [4:0] iv;
    logic [9:0] ity;
    logic       cin;
    logic [4:0] eack;
    int         osrc;
    logic       ebusy;
    logic [4:0] elock;
    int         ecred;
    logic       eerr;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: packet-level view of the output port.
  bit          m_locked;
  int          m_port;
  int          m_cred;
  bit          m_err;
  bit          m_ovalid;
  logic [31:0] m_odata;
  logic [1:0]  m_otype;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic vec_t tv(input logic r, input logic [4:0] g, input logic [4:0] v,
                              input logic [9:0] t, input logic c, input logic [4:0] ea,
                              input int os, input logic eb, input logic [4:0] el,
                              input int ec, input logic ee);
    vec_t x;
    x.rst_ = r; x.grt = g; x.iv = v; x.ity = t; x.cin = c;
    x.eack = ea; x.osrc = os; x.ebusy = eb; x.elock = el; x.ecred = ec; x.eerr = ee;
    return x;
  endfunction

  function automatic vec_t mk(input logic r, input logic [4:0] g, input logic [4:0] v,
                              input logic [9:0] t, input logic c);
    return tv(r, g, v, t, c, 5'b0, -1, 1'b0, 5'b0, 0, 1'b0);
  endfunction

  function automatic int lowest(input logic [4:0] g);
    for (int i = 0; i < PORTS; i++) if (g[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] flit_data(input int p, input logic [15:0] tag);
    return 32'hD000_0000 | (32'(p) << 16) | 32'(tag);
  endfunction

  // mode 0: drive only, 1: compare against table expectations, 2: compare against model
  task automatic run_cycle(input int mode, input vec_t e, input logic [15:0] tag);
    int         sel;
    bit         acc;
    logic [1:0] t;
    logic [4:0] mack;
    logic [4:0] mlock;
    rst_      = e.rst_;
    grt       = e.grt;
    ivalid    = e.iv;
    itype     = e.ity;
    credit_in = e.cin;
    for (int p = 0; p < PORTS; p++) idata[p*DATA_W +: DATA_W] = flit_data(p, tag);

    sel  = m_locked ? m_port : lowest(e.grt);
    t    = (sel >= 0) ? e.ity[sel*2 +: 2] : HT;
    acc  = (sel >= 0) && e.iv[sel] && (m_cred > 0) && (m_locked || t == HT || t == HD);
    mack = acc ? 5'(1 << sel) : 5'b0;
    mlock = m_locked ? 5'(1 << m_port) : 5'b0;

    @(negedge clk);
    if (mode == 1) begin
      chk("tab_iack", 64'(iack), 64'(e.eack));
      chk("tab_ovalid", 64'(ovalid), 64'(e.osrc >= 0));
      if (e.osrc >= 0) chk("tab_odata", 64'(odata), 64'(flit_data(e.osrc, 16'(tag - 1))));
      chk("tab_busy", 64'(busy), 64'(e.ebusy));
      chk("tab_lock_sel", 64'(lock_sel), 64'(e.elock));
      chk("tab_credit_cnt", 64'(credit_cnt), 64'(e.ecred));
      chk("tab_err", 64'(err), 64'(e.eerr));
    end else if (mode == 2) begin
      chk("mdl_iack", 64'(iack), 64'(mack));
      chk("mdl_ovalid", 64'(ovalid), 64'(m_ovalid));
      if (m_ovalid) begin
        chk("mdl_odata", 64'(odata), 64'(m_odata));
        chk("mdl_otype", 64'(otype), 64'(m_otype));
      end
      chk("mdl_busy", 64'(busy), 64'(m_locked));
      chk("mdl_lock_sel", 64'(lock_sel), 64'(mlock));
      chk("mdl_credit_cnt", 64'(credit_cnt), 64'(m_cred));
      chk("mdl_err", 64'(err), 64'(m_err));
    end
    $display("cycle %0d: rst_=%b grt=%b ivalid=%b cin=%b iack=%b ovalid=%b credits=%0d busy=%b err=%b",
             cyc, e.rst_, e.grt, e.iv, e.cin, iack, ovalid, credit_cnt, busy, err);

    if (!e.rst_) begin
      m_locked = 0; m_port = 0; m_cred = CREDITS; m_err = 0;
      m_ovalid = 0; m_odata = '0; m_otype = HT;
    end else begin
      if (!m_locked && sel >= 0 && e.iv[sel] && (t == BD || t == TL)) m_err = 1;
      if (m_locked && acc && (t == HD || t == HT)) m_err = 1;
      if (e.cin && !acc && m_cred == CREDITS) m_err = 1;
      else m_cred = m_cred + int'(e.cin) - int'(acc);
      m_ovalid = acc;
      if (acc) begin
        m_odata = flit_data(sel, tag);
        m_otype = t;
        if (!m_locked && t == HD) begin
          m_locked = 1; m_port = sel;
        end else if (m_locked && t == TL) begin
          m_locked = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  vec_t tab [29];
  vec_t z;

  initial begin
    z = mk(1'b0, 5'b0, 5'b0, 10'b0, 1'b0);
    m_locked = 0; m_port = 0; m_cred = CREDITS; m_err = 0;
    m_ovalid = 0; m_odata = '0; m_otype = HT;

    tab[0]  = tv(0, 5'b00000, 5'b00000, 10'b0, 0, 5'b00000, -1, 0, 5'b00000, 4, 0);
    tab[1]  = tv(1, 5'b00000, 5'b00000, 10'b0, 0, 5'b00000, -1, 0, 5'b00000, 4, 0);
    tab[2]  = tv(1, 5'b00100, 5'b00100, {HT,HT,HD,HT,HT}, 0, 5'b00100, -1, 0, 5'b00000, 4, 0);
    tab[3]  = tv(1, 5'b00000, 5'b00100, {HT,HT,BD,HT,HT}, 0, 5'b00100,  2, 1, 5'b00100, 3, 0);
    tab[4]  = tv(1, 5'b00000, 5'b00100, {HT,HT,TL,HT,HT}, 0, 5'b00100,  2, 1, 5'b00100, 2, 0);
    tab[5]  = tv(1, 5'b00000, 5'b00000, 10'b0, 0, 5'b00000,  2, 0, 5'b00000, 1, 0);
    tab[6]  = tv(1, 5'b00000, 5'b00000, 10'b0, 1, 5'b00000, -1, 0, 5'b00000, 1, 0);
    tab[7]  = tv(1, 5'b00000, 5'b00000, 10'b0, 1, 5'b00000, -1, 0, 5'b00000, 2, 0);
    tab[8]  = tv(1, 5'b00000, 5'b00000, 10'b0, 1, 5'b00000, -1, 0, 5'b00000, 3, 0);
    tab[9]  = tv(1, 5'b01000, 5'b01000, 10'b0, 0, 5'b01000, -1, 0, 5'b00000, 4, 0);
    tab[10] = tv(1, 5'b01000, 5'b01000, 10'b0, 1, 5'b01000,  3, 0, 5'b00000, 3, 0);
    tab[11] = tv(1, 5'b01000, 5'b01000, 10'b0, 1, 5'b01000,  3, 0, 5'b00000, 3, 0);
    tab[12] = tv(1, 5'b00000, 5'b00000, 10'b0, 1, 5'b00000,  3, 0, 5'b00000, 3, 0);
    tab[13] = tv(1, 5'b00000, 5'b00000, 10'b0, 0, 5'b00000, -1, 0, 5'b00000, 4, 0);
    tab[14] = tv(1, 5'b00010, 5'b00010, {HT,HT,HT,HD,HT}, 0, 5'b00010, -1, 0, 5'b00000, 4, 0);
    tab[15] = tv(1, 5'b10000, 5'b10010, {HD,HT,HT,BD,HT}, 0, 5'b00010,  1, 1, 5'b00010, 3, 0);
    tab[16] = tv(1, 5'b10000, 5'b10010, {HD,HT,HT,TL,HT}, 1, 5'b00010,  1, 1, 5'b00010, 2, 0);
    tab[17] = tv(1, 5'b10000, 5'b10000, {HD,HT,HT,HT,HT}, 1, 5'b10000,  1, 0, 5'b00000, 2, 0);
    tab[18] = tv(1, 5'b00000, 5'b10000, {TL,HT,HT,HT,HT}, 1, 5'b10000,  4, 1, 5'b10000, 2, 0);
    tab[19] = tv(1, 5'b00000, 5'b00000, 10'b0, 1, 5'b00000,  4, 0, 5'b00000, 2, 0);
    tab[20] = tv(1, 5'b00000, 5'b00000, 10'b0, 1, 5'b00000, -1, 0, 5'b00000, 3, 0);
    tab[21] = tv(1, 5'b00000, 5'b00000, 10'b0, 0, 5'b00000, -1, 0, 5'b00000, 4, 0);
    tab[22] = tv(1, 5'b00001, 5'b00001, {HT,HT,HT,HT,BD}, 0, 5'b00000, -1, 0, 5'b00000, 4, 0);
    tab[23] = tv(1, 5'b00000, 5'b00000, 10'b0, 0, 5'b00000, -1, 0, 5'b00000, 4, 1);
    tab[24] = tv(0, 5'b00000, 5'b00000, 10'b0, 0, 5'b00000, -1, 0, 5'b00000, 4, 1);
    tab[25] = tv(1, 5'b00000, 5'b00000, 10'b0, 1, 5'b00000, -1, 0, 5'b00000, 4, 0);
    tab[26] = tv(1, 5'b00000, 5'b00000, 10'b0, 0, 5'b00000, -1, 0, 5'b00000, 4, 1);
    tab[27] = tv(0, 5'b00000, 5'b00000, 10'b0, 0, 5'b00000, -1, 0, 5'b00000, 4, 1);
    tab[28] = tv(1, 5'b00000, 5'b00000, 10'b0, 0, 5'b00000, -1, 0, 5'b00000, 4, 0);

    run_cycle(0, z, 16'h0);
    run_cycle(0, z, 16'h0);
    for (int r = 0; r < 29; r++) run_cycle(1, tab[r], 16'(r));

    // Credit stall: 6-flit packet on port 0 with no returning credits.
    run_cycle(2, z, 16'h100);
    run_cycle(2, mk(1, 5'b00001, 5'b00001, {HT,HT,HT,HT,HD}, 0), 16'h101);
    for (int k = 0; k < 3; k++) run_cycle(2, mk(1, 5'b00000, 5'b00001, {HT,HT,HT,HT,BD}, 0), 16'(16'h102 + k));
    chk("stall_cred_zero", 64'(credit_cnt), 64'd0);
    chk("stall_busy", 64'(busy), 64'd1);
    run_cycle(2, mk(1, 5'b00000, 5'b00001, {HT,HT,HT,HT,BD}, 0), 16'h105);
    chk("stall_no_ovalid", 64'(ovalid), 64'd0);
    chk("stall_busy_held", 64'(busy), 64'd1);
    run_cycle(2, mk(1, 5'b00000, 5'b00001, {HT,HT,HT,HT,BD}, 1), 16'h106);
    chk("stall_cred_one", 64'(credit_cnt), 64'd1);
    chk("stall_still_no_ovalid", 64'(ovalid), 64'd0);
    run_cycle(2, mk(1, 5'b00000, 5'b00001, {HT,HT,HT,HT,BD}, 0), 16'h107);
    chk("stall_fifth_ovalid", 64'(ovalid), 64'd1);
    chk("stall_fifth_data", 64'(odata), 64'(flit_data(0, 16'h107)));
    chk("stall_cred_back_zero", 64'(credit_cnt), 64'd0);
    run_cycle(2, mk(1, 5'b00000, 5'b00001, {HT,HT,HT,HT,TL}, 1), 16'h108);
    run_cycle(2, mk(1, 5'b00000, 5'b00001, {HT,HT,HT,HT,TL}, 0), 16'h109);
    chk("stall_tail_release", 64'(busy), 64'd0);
    chk("stall_tail_type", 64'(otype), 64'(TL));

    // Reset mid-packet with err already set.
    run_cycle(2, z, 16'h200);
    run_cycle(2, mk(1, 5'b00000, 5'b00000, 10'b0, 1), 16'h201);
    chk("ovf_err", 64'(err), 64'd1);
    chk("ovf_cred", 64'(credit_cnt), 64'd4);
    run_cycle(2, mk(1, 5'b00100, 5'b00100, {HT,HT,HD,HT,HT}, 0), 16'h202);
    run_cycle(2, mk(1, 5'b00000, 5'b00100, {HT,HT,BD,HT,HT}, 0), 16'h203);
    run_cycle(2, mk(0, 5'b00000, 5'b00000, 10'b0, 0), 16'h204);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_cred", 64'(credit_cnt), 64'd4);
    chk("rst_mid_err", 64'(err), 64'd0);
    chk("rst_mid_lock", 64'(lock_sel), 64'd0);
    chk("rst_mid_ovalid", 64'(ovalid), 64'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      logic       r;
      logic [4:0] g;
      int         k;
      r = ($urandom_range(0, 59) != 0);
      k = $urandom_range(0, 9);
      if (k < 6)      g = 5'(1 << $urandom_range(0, 4));
      else if (k < 8) g = 5'b0;
      else            g = 5'($urandom_range(0, 31));
      run_cycle(2, mk(r, g, 5'($urandom_range(0, 31)), 10'($urandom), ($urandom_range(0, 2) == 0)),
                16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
